ib_queue: RTL and testbench
===========================

// Module: ib_queue
// PURPOSE
//  Parametrised in-order instruction queue between I$ and ID; successor to the fixed 4x2 instruction buffer.
//  - Accepts up to FETCH_W instructions per cycle under a lane mask; lanes are compacted in order into one circular store.
//  - Presents the oldest ISSUE_W entries to ID.
//  - Tags each entry with its PTAB address when its PC matches the predicted branch PC.
//  - Supports a full flush.
// PARAMETERS
//  FETCH_W  4   instructions per I$ group (power of 2, 2..8)
//  ISSUE_W  2   instructions offered to ID per cycle (1..FETCH_W)
//  DEPTH    16  entries (power of 2, >= 2*FETCH_W)
//  PTAB_W   5   PTAB address width; MSB = prediction-valid
// PORTS
//  clk                   in   1            clock
//  rst_                  in   1            reset; synchronous, active-high
//  flush                 in   1            discard all entries
//  icache_valid_ns       in   1            I$ group valid this cycle
//  icache_ib_pc          in   32           PC of group; low log2(FETCH_W)+2 bits ignored
//  icache_ib_insn        in   32*FETCH_W   lane i at [32*i+:32]
//  icache_ib_mask        in   FETCH_W      lane valid (alignment/branch/delay-slot truncation done upstream)
//  icache_ib_ptab_addr   in   PTAB_W       PTAB entry of predicted branch in group
//  icache_ib_branch_pc   in   32           PC of predicted branch
//  ib_allin              out  1            free entries >= FETCH_W
//  id_allin              in   1            ID accepts all offered slots this cycle
//  ib_valid_ns           out  1            ib_id_valid[0]
//  ib_id_valid           out  ISSUE_W      slot k valid when count > k
//  ib_id_pc              out  32*ISSUE_W   slot k PC, 0 when invalid
//  ib_id_insn            out  32*ISSUE_W   slot k insn, 0 when invalid
//  ib_id_ptab_addr       out  PTAB_W*ISSUE_W  slot k PTAB tag, 0 when invalid
//  ib_count              out  log2(DEPTH)+1   occupied entries
// BEHAVIOUR
//  - Reset:
//    - head, tail and count go to 0; all ib_id_* outputs are 0.
//    - ib_allin=1, ib_count=0.
//  - Push:
//    - push = icache_valid_ns & ib_allin & !flush.
//    - n_in = popcount(mask).
//    - The j-th set lane is written to entry tail+j (mod DEPTH), then tail += n_in.
//    - Lane i PC = {pc[31:log2(FETCH_W)+2], i[log2(FETCH_W)-1:0], 2'b00}.
//    - Entry ptab = (lane PC == branch_pc && ptab_addr[PTAB_W-1]) ? ptab_addr : 0.
//    - mask=0 with valid=1 is a legal no-op.
//  - Pop:
//    - n_out = id_allin ? min(count, ISSUE_W) : 0.
//    - head += n_out (mod DEPTH).
//    - Slots are always the oldest entries, in program order.
//  - count_next = count + n_in - n_out. Push and pop in the same cycle are both honoured.
//  - Latency: an entry pushed in cycle N is visible on ib_id_* in cycle N+1; no bypass.
//  - Outputs are combinational from head/count and the registered store.
//  - ib_allin = (DEPTH - count) >= FETCH_W, from registered count only.
//    - I$ is required to hold its group while ib_allin=0.
//    - A group offered while ib_allin=0 leaves state unchanged.
//  - Flush (priority over push/pop):
//    - head, tail and count go to 0 next cycle.
//    - The same-cycle push is dropped.
//    - ib_id_valid=0 from the next cycle.
//  - Reset overrides flush and any in-flight push/pop.
//  - Wrap-around: pointers are log2(DEPTH) bits and wrap naturally.
//    - Full (count=DEPTH) and empty (count=0) are distinguished by count only.
//  - count never exceeds DEPTH and never underflows.
//    - Simulation assertions fire on violation, and on any mask bit set above FETCH_W.
// STRUCTURE
//  - Shared header each_module.h gains:
//    - IB entry field locations (PTAB | PC | INSN);
//    - IB_FETCH_W / IB_ISSUE_W / IB_DEPTH defaults;
//    - `define for entry width.
//  - Sub-module ib_lane_compact:
//    - FETCH_W mask -> per-output-position source lane index, plus n_in;
//    - purely combinational.
//  - Store: DEPTH x entry register array; no SRAM macro.
// TESTING
//  - Reset release, ID stalled, 4 full groups (mask 1111) at PC 0x1000/0x1010/0x1020/0x1030:
//    - ib_count=16, ib_allin=0;
//    - slot0 PC=0x1000, slot1 PC=0x1004.
//  - Masks 1110, 1100, 1000, 0001 on 4 groups; id_allin=1 afterwards:
//    - PC sequence 0x1004,0x1008,0x100C,0x1018,0x101C,0x102C,0x1030, two per cycle;
//    - ib_id_valid=01 on the final cycle.
//  - branch_pc=0x1008, ptab_addr=5'b10011, mask=0111:
//    - entry 0x1008 carries 5'b10011, the others 0;
//    - repeat with ptab_addr=5'b00011: all entries carry 0.
//  - Steady state, id_allin=1, one full group per cycle:
//    - count grows by 2 per cycle until ib_allin=0 at count 13;
//    - thereafter no loss or duplication across pointer wrap.
//  - Flush with count=9 and a same-cycle push:
//    - next cycle count=0, ib_id_valid=00;
//    - the group pushed after flush appears first.
//  - rst_=1 mid-stream during simultaneous push+pop:
//    - next cycle all outputs 0, ib_allin=1, ib_count=0.

Source files
------------

// File: rtl/ib_queue_pkg.sv
// Shared definitions for the instruction buffer: default geometry and the
// bit layout of one stored entry (PTAB | PC | INSN, MSB to LSB).
package ib_queue_pkg;

    localparam int IB_FETCH_W = 4;
    localparam int IB_ISSUE_W = 2;
    localparam int IB_DEPTH   = 16;
    localparam int IB_PTAB_W  = 5;

    localparam int IB_INSN_LSB = 0;
    localparam int IB_PC_LSB   = 32;
    localparam int IB_PTAB_LSB = 64;

    function automatic int ib_entry_w(input int ptab_w);
        return IB_PTAB_LSB + ptab_w;
    endfunction

endpackage

// File: rtl/ib_lane_compact.sv
// Turns an I$ lane mask into, for each compacted output position, the index of
// the source lane that lands there, plus the number of valid lanes.
module ib_lane_compact
    import ib_queue_pkg::*;
#(
    parameter int FETCH_W = IB_FETCH_W,
    localparam int LANE_W = $clog2(FETCH_W)
) (
    input  logic [FETCH_W-1:0]        i_mask,
    output logic [FETCH_W*LANE_W-1:0] o_src,
    output logic [FETCH_W-1:0]        o_pos_valid,
    output logic [LANE_W:0]           o_n_in
);

    // One-hot destination position of every lane (zero when the lane is off).
    logic [FETCH_W-1:0] w_hit [FETCH_W];

    assign o_n_in = (LANE_W+1)'($countones(i_mask));

    for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane
        logic [LANE_W:0] w_pre;
        assign w_pre      = (LANE_W+1)'($countones(i_mask & FETCH_W'((1 << gi) - 1)));
        assign w_hit[gi]  = i_mask[gi] ? (FETCH_W'(1) << w_pre) : '0;
    end

    for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_pos
        logic [LANE_W-1:0] w_src;
        always_comb begin
            w_src = '0;
            for (int i = 0; i < FETCH_W; i++) begin
                if (w_hit[i][gi]) begin
                    w_src = w_src | LANE_W'(i);
                end
            end
        end
        assign o_src[gi*LANE_W +: LANE_W] = w_src;
        assign o_pos_valid[gi]            = o_n_in > (LANE_W+1)'(gi);
    end

endmodule

// File: rtl/ib_queue.sv
// In-order instruction queue between I$ and ID: compacts masked fetch lanes into
// a circular register store and offers the oldest ISSUE_W entries to ID.
module ib_queue
    import ib_queue_pkg::*;
#(
    parameter int FETCH_W = IB_FETCH_W,
    parameter int ISSUE_W = IB_ISSUE_W,
    parameter int DEPTH   = IB_DEPTH,
    parameter int PTAB_W  = IB_PTAB_W
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic                      flush,
    input  logic                      icache_valid_ns,
    input  logic [31:0]               icache_ib_pc,
    input  logic [32*FETCH_W-1:0]     icache_ib_insn,
    input  logic [FETCH_W-1:0]        icache_ib_mask,
    input  logic [PTAB_W-1:0]         icache_ib_ptab_addr,
    input  logic [31:0]               icache_ib_branch_pc,
    output logic                      ib_allin,
    input  logic                      id_allin,
    output logic                      ib_valid_ns,
    output logic [ISSUE_W-1:0]        ib_id_valid,
    output logic [32*ISSUE_W-1:0]     ib_id_pc,
    output logic [32*ISSUE_W-1:0]     ib_id_insn,
    output logic [PTAB_W*ISSUE_W-1:0] ib_id_ptab_addr,
    output logic [$clog2(DEPTH):0]    ib_count
);

    localparam int LANE_W  = $clog2(FETCH_W);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ib_entry_w(PTAB_W);

    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [ENTRY_W-1:0] r_store [DEPTH];

    logic [FETCH_W*LANE_W-1:0] w_src;
    logic [FETCH_W-1:0]        w_pos_valid;
    logic [LANE_W:0]           w_n_in;
    logic [ENTRY_W-1:0]        w_lane_entry [FETCH_W];
    logic                      w_push;
    logic [CNT_W-1:0]          w_n_in_eff;
    logic [CNT_W-1:0]          w_n_out;
    logic                      w_unused;

    ib_lane_compact #(
        .FETCH_W(FETCH_W)
    ) u_compact (
        .i_mask      (icache_ib_mask),
        .o_src       (w_src),
        .o_pos_valid (w_pos_valid),
        .o_n_in      (w_n_in)
    );

    // Lane offset within the fetch group replaces the ignored low PC bits.
    assign w_unused = ^icache_ib_pc[LANE_W+1:0];

    for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane
        logic [31:0]       w_pc;
        logic [PTAB_W-1:0] w_ptab;
        assign w_pc   = {icache_ib_pc[31:LANE_W+2], LANE_W'(gi), 2'b00};
        assign w_ptab = (w_pc == icache_ib_branch_pc && icache_ib_ptab_addr[PTAB_W-1])
                        ? icache_ib_ptab_addr : '0;
        assign w_lane_entry[gi] = {w_ptab, w_pc, icache_ib_insn[32*gi +: 32]};
    end

    assign ib_allin   = (CNT_W'(DEPTH) - r_count) >= CNT_W'(FETCH_W);
    assign w_push     = icache_valid_ns & ib_allin & ~flush;
    assign w_n_in_eff = w_push ? CNT_W'(w_n_in) : '0;
    assign w_n_out    = !id_allin ? '0
                      : (r_count < CNT_W'(ISSUE_W)) ? r_count : CNT_W'(ISSUE_W);

    always_ff @(posedge clk) begin
        if (rst_ || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_n_out[PTR_W-1:0];
            r_tail  <= r_tail + w_n_in_eff[PTR_W-1:0];
            r_count <= r_count + w_n_in_eff - w_n_out;
        end
    end

    // Store contents need no reset: every slot read is gated by count.
    always_ff @(posedge clk) begin
        if (w_push && !rst_) begin
            for (int p = 0; p < FETCH_W; p++) begin
                if (w_pos_valid[p]) begin
                    r_store[r_tail + PTR_W'(p)] <= w_lane_entry[w_src[p*LANE_W +: LANE_W]];
                end
            end
        end
    end

    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_slot
        logic               w_valid;
        logic [ENTRY_W-1:0] w_entry;
        assign w_valid         = r_count > CNT_W'(gi);
        assign w_entry         = w_valid ? r_store[r_head + PTR_W'(gi)] : '0;
        assign ib_id_valid[gi] = w_valid;
        assign ib_id_insn[32*gi +: 32]          = w_entry[IB_INSN_LSB +: 32];
        assign ib_id_pc[32*gi +: 32]            = w_entry[IB_PC_LSB +: 32];
        assign ib_id_ptab_addr[PTAB_W*gi +: PTAB_W] = w_entry[IB_PTAB_LSB +: PTAB_W];
    end

    assign ib_valid_ns = ib_id_valid[0];
    assign ib_count    = r_count;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            assert (r_count <= CNT_W'(DEPTH));
            assert (!w_push || (r_count + CNT_W'(w_n_in) <= CNT_W'(DEPTH)));
            assert (w_n_in <= (LANE_W+1)'(FETCH_W));
            assert (w_n_out <= r_count + w_n_in_eff);
        end
    end

endmodule

// File: tb/tb_ib_queue.sv
// Scoreboard bench for ib_queue: accepted lanes are queued in program order,
// popped and compared as ID consumes them, and the queue head is checked each cycle.
module tb_ib_queue;

    localparam int FETCH_W = 4;
    localparam int ISSUE_W = 2;
    localparam int DEPTH   = 16;
    localparam int PTAB_W  = 5;

    logic                      clk = 1'b0;
    logic                      rst_;
    logic                      flush;
    logic                      icache_valid_ns;
    logic [31:0]               icache_ib_pc;
    logic [32*FETCH_W-1:0]     icache_ib_insn;
    logic [FETCH_W-1:0]        icache_ib_mask;
    logic [PTAB_W-1:0]         icache_ib_ptab_addr;
    logic [31:0]               icache_ib_branch_pc;
    logic                      ib_allin;
    logic                      id_allin;
    logic                      ib_valid_ns;
    logic [ISSUE_W-1:0]        ib_id_valid;
    logic [32*ISSUE_W-1:0]     ib_id_pc;
    logic [32*ISSUE_W-1:0]     ib_id_insn;
    logic [PTAB_W*ISSUE_W-1:0] ib_id_ptab_addr;
    logic [$clog2(DEPTH):0]    ib_count;

    ib_queue #(
        .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .PTAB_W(PTAB_W)
    ) dut (
        .clk                 (clk),
        .rst_                (rst_),
        .flush               (flush),
        .icache_valid_ns     (icache_valid_ns),
        .icache_ib_pc        (icache_ib_pc),
        .icache_ib_insn      (icache_ib_insn),
        .icache_ib_mask      (icache_ib_mask),
        .icache_ib_ptab_addr (icache_ib_ptab_addr),
        .icache_ib_branch_pc (icache_ib_branch_pc),
        .ib_allin            (ib_allin),
        .id_allin            (id_allin),
        .ib_valid_ns         (ib_valid_ns),
        .ib_id_valid         (ib_id_valid),
        .ib_id_pc            (ib_id_pc),
        .ib_id_insn          (ib_id_insn),
        .ib_id_ptab_addr     (ib_id_ptab_addr),
        .ib_count            (ib_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PTAB_W-1:0] ptab;
        logic [31:0]       pc;
        logic [31:0]       insn;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   seq    = 0;
    logic acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic verify();
        check("count", 64'(ib_count), 64'(sb.size()));
        check("allin", 64'(ib_allin), 64'((DEPTH - sb.size()) >= FETCH_W));
        check("valid_ns", 64'(ib_valid_ns), 64'(sb.size() > 0));
        for (int k = 0; k < ISSUE_W; k++) begin
            if (k < sb.size()) begin
                check($sformatf("slot%0d_valid", k), 64'(ib_id_valid[k]), 64'(1));
                check($sformatf("slot%0d_pc", k), 64'(ib_id_pc[32*k +: 32]), 64'(sb[k].pc));
                check($sformatf("slot%0d_insn", k), 64'(ib_id_insn[32*k +: 32]), 64'(sb[k].insn));
                check($sformatf("slot%0d_ptab", k), 64'(ib_id_ptab_addr[PTAB_W*k +: PTAB_W]),
                      64'(sb[k].ptab));
            end else begin
                check($sformatf("slot%0d_valid", k), 64'(ib_id_valid[k]), 64'(0));
                check($sformatf("slot%0d_zero", k),
                      64'({ib_id_pc[32*k +: 32], ib_id_insn[32*k +: 32]} | 64'(ib_id_ptab_addr[PTAB_W*k +: PTAB_W])),
                      64'(0));
            end
        end
    endtask

    // One clock of stimulus; acc reports whether the group is taken in.
    task automatic step(input logic rs, input logic fl, input logic v, input logic [31:0] pc,
                        input logic [FETCH_W-1:0] mask, input logic id,
                        input logic [PTAB_W-1:0] pt, input logic [31:0] bpc,
                        output logic a);
        ent_t        e;
        int          n_out;
        logic [31:0] lpc;
        @(negedge clk);
        rst_ = rs;  flush = fl;  icache_valid_ns = v;  icache_ib_pc = pc;
        icache_ib_mask = mask;  id_allin = id;
        icache_ib_ptab_addr = pt;  icache_ib_branch_pc = bpc;
        for (int i = 0; i < FETCH_W; i++) icache_ib_insn[32*i +: 32] = {8'(i), 24'(seq)};
        a = !rs && !fl && v && ((DEPTH - sb.size()) >= FETCH_W);
        if (rs || fl) begin
            sb.delete();
        end else begin
            n_out = id ? ((sb.size() < ISSUE_W) ? sb.size() : ISSUE_W) : 0;
            for (int k = 0; k < n_out; k++) begin
                e = sb.pop_front();
                check($sformatf("pop%0d_pc", k), 64'(ib_id_pc[32*k +: 32]), 64'(e.pc));
                check($sformatf("pop%0d_insn", k), 64'(ib_id_insn[32*k +: 32]), 64'(e.insn));
                check($sformatf("pop%0d_ptab", k), 64'(ib_id_ptab_addr[PTAB_W*k +: PTAB_W]), 64'(e.ptab));
            end
            if (a) begin
                for (int i = 0; i < FETCH_W; i++) begin
                    if (mask[i]) begin
                        lpc    = {pc[31:4], 4'b0000} + 32'(i * 4);
                        e.pc   = lpc;
                        e.insn = {8'(i), 24'(seq)};
                        e.ptab = (lpc == bpc && pt[PTAB_W-1]) ? pt : '0;
                        sb.push_back(e);
                    end
                end
            end
        end
        seq++;
        @(posedge clk);
        #1;
        $display("txn %0d rst=%0b flush=%0b v=%0b pc=%08h mask=%04b id=%0b -> count=%0d allin=%0b valid=%02b slot0=%08h",
                 seq, rs, fl, v, pc, mask, id, ib_count, ib_allin, ib_id_valid, ib_id_pc[31:0]);
        verify();
    endtask

    task automatic push(input logic [31:0] pc, input logic [FETCH_W-1:0] mask, input logic id);
        step(1'b0, 1'b0, 1'b1, pc, mask, id, '0, 32'hFFFF_FFFF, acc);
    endtask

    task automatic idle(input logic id);
        step(1'b0, 1'b0, 1'b0, 32'h0, '0, id, '0, 32'hFFFF_FFFF, acc);
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && sb.size() > 0; t++) idle(1'b1);
        check("drained", 64'(ib_count), 64'(0));
    endtask

    initial begin
        logic [31:0] pc;
        rst_ = 1'b1;  flush = 1'b0;  icache_valid_ns = 1'b0;  icache_ib_pc = '0;
        icache_ib_insn = '0;  icache_ib_mask = '0;  icache_ib_ptab_addr = '0;
        icache_ib_branch_pc = '0;  id_allin = 1'b0;

        step(1'b1, 1'b0, 1'b0, 32'h0, '0, 1'b0, '0, 32'h0, acc);
        step(1'b1, 1'b0, 1'b0, 32'h0, '0, 1'b0, '0, 32'h0, acc);
        check("rst_count", 64'(ib_count), 64'(0));
        check("rst_allin", 64'(ib_allin), 64'(1));
        check("rst_valid", 64'(ib_id_valid), 64'(0));

        // Fill with ID stalled, then offer a group while full.
        for (int g = 0; g < 4; g++) push(32'h1000 + 32'(g * 16), 4'b1111, 1'b0);
        check("t1_count", 64'(ib_count), 64'(16));
        check("t1_allin", 64'(ib_allin), 64'(0));
        check("t1_pc0", 64'(ib_id_pc[31:0]), 64'h1000);
        check("t1_pc1", 64'(ib_id_pc[63:32]), 64'h1004);
        push(32'h1040, 4'b1111, 1'b0);
        check("t1_hold_count", 64'(ib_count), 64'(16));
        drain();

        // Partial masks and a mask=0 no-op.
        push(32'h1000, 4'b1110, 1'b0);
        push(32'h1010, 4'b1100, 1'b0);
        push(32'h1020, 4'b1000, 1'b0);
        push(32'h1030, 4'b0001, 1'b0);
        push(32'h1040, 4'b0000, 1'b0);
        check("t2_count", 64'(ib_count), 64'(7));
        check("t2_first", 64'(ib_id_pc[31:0]), 64'h1004);
        for (int t = 0; t < 3; t++) idle(1'b1);
        check("t2_valid_last", 64'(ib_id_valid), 64'(2'b01));
        check("t2_pc_last", 64'(ib_id_pc[31:0]), 64'h1030);
        idle(1'b1);
        check("t2_empty", 64'(ib_count), 64'(0));

        // PTAB tagging with prediction valid and invalid.
        step(1'b0, 1'b0, 1'b1, 32'h1000, 4'b0111, 1'b0, 5'b10011, 32'h1008, acc);
        idle(1'b1);
        check("t3_pc", 64'(ib_id_pc[31:0]), 64'h1008);
        check("t3_tag", 64'(ib_id_ptab_addr[4:0]), 64'(5'b10011));
        idle(1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h1000, 4'b0111, 1'b0, 5'b00011, 32'h1008, acc);
        idle(1'b1);
        check("t3_pc_np", 64'(ib_id_pc[31:0]), 64'h1008);
        check("t3_tag_np", 64'(ib_id_ptab_addr[4:0]), 64'(0));
        drain();

        // Steady state: three entries prefilled, then a full group per cycle.
        push(32'h2000, 4'b0111, 1'b0);
        pc = 32'h2010;
        for (int t = 0; t < 5; t++) begin
            step(1'b0, 1'b0, 1'b1, pc, 4'b1111, 1'b1, '0, 32'hFFFF_FFFF, acc);
            if (acc) pc += 32'h10;
        end
        check("t4_count13", 64'(ib_count), 64'(13));
        check("t4_allin0", 64'(ib_allin), 64'(0));
        for (int t = 0; t < 30; t++) begin
            step(1'b0, 1'b0, 1'b1, pc, 4'b1111, 1'b1, '0, 32'hFFFF_FFFF, acc);
            if (acc) pc += 32'h10;
        end
        drain();

        // Flush at count 9 with a same-cycle push and pop request.
        push(32'h3000, 4'b1111, 1'b0);
        push(32'h3010, 4'b1111, 1'b0);
        push(32'h3020, 4'b0001, 1'b0);
        check("t5_count9", 64'(ib_count), 64'(9));
        step(1'b0, 1'b1, 1'b1, 32'h5000, 4'b1111, 1'b1, '0, 32'hFFFF_FFFF, acc);
        check("t5_flush_count", 64'(ib_count), 64'(0));
        check("t5_flush_valid", 64'(ib_id_valid), 64'(0));
        push(32'h6000, 4'b1111, 1'b0);
        check("t5_after_pc0", 64'(ib_id_pc[31:0]), 64'h6000);
        check("t5_after_pc1", 64'(ib_id_pc[63:32]), 64'h6004);
        drain();

        // Reset during simultaneous push and pop.
        push(32'h7000, 4'b1111, 1'b0);
        push(32'h7010, 4'b1111, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h7020, 4'b1111, 1'b1, '0, 32'hFFFF_FFFF, acc);
        check("t6_count", 64'(ib_count), 64'(0));
        check("t6_allin", 64'(ib_allin), 64'(1));
        check("t6_valid", 64'(ib_id_valid), 64'(0));
        check("t6_outs", 64'(ib_id_pc | ib_id_insn | 64'(ib_id_ptab_addr)), 64'(0));
        idle(1'b0);
        push(32'h8000, 4'b0011, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
